// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package wb_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] hot;
    hot     = '0;
    hot[rd] = 1'b1;
    return hot;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Memory-result buffer: circular FIFO of wb_entry_t with a kill-by-rd port
// and a flat live/rd view so the top can build the busy map.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  input  logic                    kill_valid,
  input  logic [REG_AW-1:0]       kill_rd,
  output wb_entry_t               head,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        live_vec,
  output logic [DEPTH*REG_AW-1:0] rd_vec
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [DEPTH-1:0]  live_reg;
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Popped slots drop their live bit so busy only ever sees occupied entries.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      live_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr_reg == AW'(i))
          live_reg[i] <= push_entry.live;
        else if (pop && rd_ptr_reg == AW'(i))
          live_reg[i] <= 1'b0;
        else if (kill_valid && rd_mem[i] == kill_rd)
          live_reg[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= push_entry.rd;
      data_mem[wr_ptr_reg] <= push_entry.data;
    end
  end

  assign head.live = live_reg[rd_ptr_reg];
  assign head.rd   = rd_mem[rd_ptr_reg];
  assign head.data = data_mem[rd_ptr_reg];

  assign live_vec = live_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_view
    assign rd_vec[gi*REG_AW +: REG_AW] = rd_mem[gi];
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Serializes ALU and buffered memory results onto one register-file write
// port; ALU always wins, memory drains in idle slots, with busy/starve export.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic              mem_valid_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  output logic              mem_ready_o,
  output logic              RegWrite_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [XLEN-1:0]   RDdata_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic              starve_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                    alu_win;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  wb_entry_t               push_entry;
  wb_entry_t               head;
  logic [DEPTH-1:0]        live_vec;
  logic [DEPTH*REG_AW-1:0] rd_vec;

  logic              reg_write_reg;
  logic [REG_AW-1:0] rd_addr_reg;
  logic [XLEN-1:0]   rd_data_reg;
  logic [SW-1:0]     starve_cnt_reg;

  // Writes to x0 never arbitrate and never get buffered.
  assign alu_win     = alu_valid_i && (alu_rd_i != '0);
  assign mem_ready_o = !fifo_full;
  assign fifo_push   = mem_valid_i && !fifo_full && (mem_rd_i != '0);
  assign fifo_pop    = !alu_win && !fifo_empty;

  assign push_entry.live = !(alu_win && alu_rd_i == mem_rd_i);
  assign push_entry.rd   = mem_rd_i;
  assign push_entry.data = mem_data_i;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill_valid (alu_win),
    .kill_rd    (alu_rd_i),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .live_vec   (live_vec),
    .rd_vec     (rd_vec)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      reg_write_reg <= 1'b0;
      rd_addr_reg   <= '0;
      rd_data_reg   <= '0;
    end else if (alu_win) begin
      reg_write_reg <= 1'b1;
      rd_addr_reg   <= alu_rd_i;
      rd_data_reg   <= alu_data_i;
    end else if (fifo_pop && head.live) begin
      reg_write_reg <= 1'b1;
      rd_addr_reg   <= head.rd;
      rd_data_reg   <= head.data;
    end else begin
      reg_write_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || fifo_empty || fifo_pop)
      starve_cnt_reg <= '0;
    else if (alu_win && starve_cnt_reg != SW'(STARVE_MAX))
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
  end

  assign RegWrite_o = reg_write_reg;
  assign RDaddr_o   = rd_addr_reg;
  assign RDdata_o   = rd_data_reg;
  assign starve_o   = (starve_cnt_reg == SW'(STARVE_MAX));

  logic [NUM_REGS-1:0] entry_hot [DEPTH];
  logic [NUM_REGS-1:0] busy_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign entry_hot[gi] = live_vec[gi] ? rd_onehot(rd_vec[gi*REG_AW +: REG_AW]) : '0;
  end

  always_comb begin
    busy_next = '0;
    for (int i = 0; i < DEPTH; i++) busy_next = busy_next | entry_hot[i];
  end

  assign busy_o = {busy_next[NUM_REGS-1:1], 1'b0};
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based
// reference model of the writeback rules.
module tb_writeback_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        mem_valid_i = 1'b0;
  logic [4:0]  mem_rd_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_ready_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [31:0] busy_o;
  logic        starve_o;

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .mem_valid_i (mem_valid_i),
    .mem_rd_i    (mem_rd_i),
    .mem_data_i  (mem_data_i),
    .mem_ready_o (mem_ready_o),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o),
    .busy_o      (busy_o),
    .starve_o    (starve_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ref_entry_t;

  ref_entry_t  ref_q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          exp_losses;

  int checks_made   = 0;
  int checks_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_made++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_busy();
    logic [31:0] b;
    b = '0;
    foreach (ref_q[i]) if (ref_q[i].live) b[ref_q[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic check_outputs();
    check_val("regwrite", 32'(RegWrite_o), 32'(exp_we));
    check_val("rdaddr",   32'(RDaddr_o),   32'(exp_addr));
    check_val("rddata",   RDdata_o,        exp_data);
    check_val("busy",     busy_o,          ref_busy());
    check_val("mem_ready", 32'(mem_ready_o), 32'(ref_q.size() < DEPTH));
    check_val("starve",   32'(starve_o),   32'(exp_losses == STARVE_MAX));
    if (RegWrite_o === 1'b1)
      $display("write rd=%0d data=%h t=%0t", RDaddr_o, RDdata_o, $time);
  endtask

  task automatic ref_reset();
    ref_q.delete();
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    exp_losses = 0;
  endtask

  // Called at a negedge: drives one cycle of inputs, advances the model,
  // then checks the DUT at the following negedge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit         alu_wins;
    bit         ready;
    bit         was_nonempty;
    bit         popped;
    ref_entry_t e;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;

    alu_wins     = av && (ard != 0);
    ready        = ref_q.size() < DEPTH;
    was_nonempty = ref_q.size() > 0;
    popped       = 1'b0;
    if (alu_wins) begin
      foreach (ref_q[i]) if (ref_q[i].rd == ard) ref_q[i].live = 1'b0;
      exp_we = 1'b1; exp_addr = ard; exp_data = ad;
    end else if (was_nonempty) begin
      e = ref_q.pop_front();
      popped = 1'b1;
      if (e.live) begin
        exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
      end else begin
        exp_we = 1'b0;
      end
    end else begin
      exp_we = 1'b0;
    end
    if (mv && ready && mrd != 0) begin
      e.rd = mrd; e.data = md; e.live = !(alu_wins && ard == mrd);
      ref_q.push_back(e);
    end
    if (!was_nonempty || popped) exp_losses = 0;
    else if (alu_wins && exp_losses < STARVE_MAX) exp_losses++;

    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    alu_valid_i = $urandom_range(0, 1);
    mem_valid_i = $urandom_range(0, 1);
    ref_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ref_reset();
    @(negedge clk_i);
    do_reset();

    // ALU only
    step(1, 5, 32'h1234, 0, 0, 0);
    check_val("alu_only_data", RDdata_o, 32'h1234);
    idle(2);

    // Memory drain
    step(0, 0, 0, 1, 7, 32'hAA);
    check_val("drain_busy7", 32'(busy_o[7]), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check_val("drain_addr", 32'(RDaddr_o), 32'd7);
    check_val("drain_busy_clr", busy_o, 32'd0);
    idle(1);

    // Kill: head held by ALU, then killed, then popped dead
    step(1, 1, 32'h11, 1, 3, 32'hAA);
    step(1, 3, 32'h55, 0, 0, 0);
    check_val("kill_busy3", busy_o, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check_val("kill_dead_pop", 32'(RegWrite_o), 32'd0);
    idle(1);

    // Full / starvation
    for (int i = 0; i < 4; i++) step(1, 2, 32'(i), 1, 5'(4 + i), 32'hB0 + 32'(i));
    check_val("full_ready", 32'(mem_ready_o), 32'd0);
    for (int i = 0; i < 10; i++) step(1, 2, 32'h100 + 32'(i), 0, 0, 0);
    check_val("starve_set", 32'(starve_o), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check_val("after_pop_ready", 32'(mem_ready_o), 32'd1);
    check_val("after_pop_starve", 32'(starve_o), 32'd0);
    idle(4);

    // x0 and reset mid-operation
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    check_val("x0_nowrite", 32'(RegWrite_o), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 9, 32'(i), 1, 5'(10 + i), 32'(i));
    do_reset();
    check_val("rst_busy", busy_o, 32'd0);
    idle(3);

    // Random phases with varying ALU pressure
    for (int p = 0; p < 4; p++) begin
      int alu_pct;
      alu_pct = (p == 0) ? 80 : (p == 1) ? 50 : (p == 2) ? 20 : 95;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        step(($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_made, checks_failed);
    $finish;
  end
endmodule
